uart_tx_fifo_ctrl: RTL

UART_TX_FIFO_CTRL -- requirements
Module: uart_tx_fifo_ctrl

---
 rtl/uart_tx_fifo_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_ctrl
//
// Queues bytes in a circular FIFO and feeds them one at a time to a downstream
// UART transmitter. A small control FSM pops the head byte into a holding
// register, issues a one-cycle tx_start, then waits for the transmitter's
// tx_done_tick before fetching the next byte.
//
// Ports:
//   clk           sole clock, rising edge
//   reset         asynchronous, active-low reset (0 = in reset)
//   wr_en         push request for wr_data
//   wr_data       byte to queue (DBIT bits)
//   ovf_clr       synchronous clear of the sticky overflow flag
//   tx_done_tick  one-cycle "frame finished" pulse from the transmitter
//   tx_start      one-cycle start request to the transmitter
//   tx_din        registered byte for the transmitter (DBIT bits)
//   full          FIFO holds 2**ADDR_W entries
//   empty         FIFO holds no entries
//   count         FIFO occupancy (ADDR_W+1 bits)
//   overflow      sticky flag: a write was dropped because the FIFO was full
//   busy          FSM not idle, or FIFO not empty
// ---------------------------------------------------------------------------
module uart_tx_fifo_ctrl #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    input  logic              ovf_clr,
    input  logic              tx_done_tick,
    output logic              tx_start,
    output logic [DBIT-1:0]   tx_din,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              busy
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_DONE
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [DBIT-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;
    logic [DBIT-1:0]   tx_din_q;

    logic              wr_accept;
    logic              wr_drop;
    logic              pop;

    // Flags come only from the registered occupancy, so wr_en never reaches
    // full/empty/count combinationally.
    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

    // A drop is decided purely on the registered full flag: a pop on the same
    // edge does not make room for the incoming byte.
    assign wr_accept = wr_en && !full;
    assign wr_drop   = wr_en && full;

    // The FSM pops only from IDLE, so a pop always lands on a non-empty FIFO
    // and rd_ptr never equals wr_ptr while a write is being accepted.
    assign pop = (state == IDLE) && !empty;

    assign overflow = overflow_q;
    assign tx_din   = tx_din_q;

    // Storage array carries no reset; stale contents are unreachable because
    // the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and explicit occupancy counter; a simultaneous push and pop
    // advances both pointers and leaves the count untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow: a drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (wr_drop) begin
            overflow_q <= 1'b1;
        end else if (ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    // Holding register for the transmitter; it only changes on a pop, so the
    // byte stays stable through tx_start and the whole frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_din_q <= '0;
        end else if (pop) begin
            tx_din_q <= mem[rd_ptr];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. tx_done_tick is only looked at in WAIT_DONE, so a
    // stray pulse in IDLE or LOAD has no effect.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done_tick) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state. LOAD always lasts exactly
    // one cycle, so tx_start can never be high on two consecutive cycles.
    always_comb begin
        tx_start = (state == LOAD);
        busy     = (state != IDLE) || !empty;
    end

endmodule
